// File: rtl/lcv_mul_acc_seq.sv
// Sequencer for a shared 16x16 signed multiply-accumulate datapath with a 33-bit accumulator.
// Takes a job (length + bias), streams operand pairs through a registered product stage and
// returns the accumulated result with a sticky overflow flag.
module lcv_mul_acc_seq #(
  parameter int unsigned LEN_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [32:0]      cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [32:0]      res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [32:0]       acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       prod_q, prod_d;
  logic              pv_q, pv_d;

  logic [33:0]       sum;
  logic              sum_ovf;
  logic [32:0]       acc_upd;

  // All handshake outputs decode from registered state only.
  assign cmd_ready = (state_q == StIdle);
  assign op_ready  = (state_q == StRun);
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;

  // 34-bit sum so that bits [33] and [32] disagree exactly on signed overflow.
  always_comb begin
    sum     = {acc_q[32], acc_q} + {{2{prod_q[31]}}, prod_q};
    sum_ovf = sum[33] ^ sum[32];
    acc_upd = sum[32:0];
    if (SATURATE && sum_ovf) begin
      acc_upd = sum[33] ? {1'b1, 32'h0000_0000} : {1'b0, 32'hFFFF_FFFF};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    pv_d    = 1'b0;

    if (pv_q) begin
      acc_d = acc_upd;
      if (sum_ovf) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          acc_d   = cmd_bias;
          ovf_d   = 1'b0;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (op_valid) begin
          prod_d = $signed(op_a) * $signed(op_b);
          pv_d   = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        state_d = StDone;
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_seq.sv
// Self-checking bench for lcv_mul_acc_seq: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic dot-product model.
module tb_lcv_mul_acc_seq;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic [32:0]      cmd_bias;
  logic             op_valid;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             res_ready;

  logic        cmd_ready, op_ready, res_valid, res_ovf, busy;
  logic [32:0] res_data;
  logic        cmd_ready_s, op_ready_s, res_valid_s, res_ovf_s, busy_s;
  logic [32:0] res_data_s;

  int n_pass;
  int n_tot;
  int cyc;
  int op_cnt;

  logic signed [15:0] pa [0:255];
  logic signed [15:0] pb [0:255];

  lcv_mul_acc_seq #(.LEN_W(LEN_W), .SATURATE(1'b0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_bias  (cmd_bias),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  lcv_mul_acc_seq #(.LEN_W(LEN_W), .SATURATE(1'b1)) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready_s),
    .cmd_len   (cmd_len),
    .cmd_bias  (cmd_bias),
    .op_valid  (op_valid),
    .op_ready  (op_ready_s),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid_s),
    .res_ready (res_ready),
    .res_data  (res_data_s),
    .res_ovf   (res_ovf_s),
    .busy      (busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Reference: plain signed arithmetic on the whole dot product.
  function automatic void model(input int len, input logic [32:0] bias, input bit sat,
                                output logic [32:0] res, output bit ovf);
    longint acc;
    longint s;
    longint max_v;
    longint min_v;
    max_v = 64'sd4294967295;
    min_v = -64'sd4294967296;
    acc   = longint'($signed(bias));
    ovf   = 1'b0;
    for (int i = 0; i < len; i++) begin
      s = acc + longint'(pa[i]) * longint'(pb[i]);
      if (s > max_v || s < min_v) begin
        ovf = 1'b1;
        if (sat) s = (s > max_v) ? max_v : min_v;
        else     s = (s > max_v) ? s - 64'sd8589934592 : s + 64'sd8589934592;
      end
      acc = s;
    end
    res = acc[32:0];
  endfunction

  // Advance to 1ns after the next rising edge, tallying cycles with op_ready high.
  task automatic tick();
    if (op_ready) op_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int len, input logic [32:0] bias, input int gmin, input int gmax,
                         input int hold,
                         output logic [32:0] d0, output logic [32:0] d1,
                         output logic o0, output logic o1,
                         output int lat, output int opc, output int cmdw,
                         output bit unstable, output bit cmd_seen, output bit tmo);
    int w;
    int t_last;
    lat = 0; opc = 0; cmdw = 0; unstable = 1'b0; cmd_seen = 1'b0; tmo = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_bias  = bias;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    cmdw = w;
    if (!cmd_ready) tmo = 1'b1;
    tick();
    cmd_valid = 1'b0;
    op_cnt    = 0;
    t_last    = cyc;
    for (int i = 0; i < len && !tmo; i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      for (int k = 0; k < g; k++) tick();
      op_valid = 1'b1;
      op_a     = pa[i];
      op_b     = pb[i];
      w = 0;
      while (!op_ready && w < 50) begin tick(); w++; end
      if (!op_ready) tmo = 1'b1;
      tick();
      t_last   = cyc;
      op_valid = 1'b0;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
    end
    w = 0;
    while (!res_valid && w < 50) begin tick(); w++; end
    if (!res_valid || !res_valid_s) tmo = 1'b1;
    lat = cyc - t_last + 1;
    d0 = res_data; d1 = res_data_s; o0 = res_ovf; o1 = res_ovf_s;
    cmd_valid = (hold > 0);
    cmd_len   = LEN_W'($urandom_range(5, 1));
    for (int k = 0; k < hold; k++) begin
      if (cmd_ready) cmd_seen = 1'b1;
      tick();
      if (!res_valid || res_data !== d0 || res_data_s !== d1 || res_ovf !== o0 ||
          res_ovf_s !== o1) unstable = 1'b1;
    end
    opc       = op_cnt;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  logic [32:0] d0, d1, e0, e1;
  logic        o0, o1;
  bit          eo0, eo1, unst, cseen, tmo;
  int          lat, opc, cmdw;

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({cmd_ready, op_ready, res_valid, busy, res_ovf} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, op_ready, res_valid, busy, res_ovf});
    else n_pass++;
    n_tot++;
    if (res_data !== 33'd0 || res_data_s !== 33'd0)
      $display("FAIL reset_data: got %0h/%0h want 0", res_data, res_data_s);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pa[0] = 2; pb[0] = 3; pa[1] = -4; pb[1] = 5; pa[2] = 100; pb[2] = 100;
    run_job(3, 33'd10, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (tmo) $display("FAIL basic_timeout: handshake did not complete, required completion");
    else n_pass++;
    n_tot++;
    if ($signed(d0) !== 33'sd9996 || $signed(d1) !== 33'sd9996 || o0 !== 1'b0 || o1 !== 1'b0)
      $display("FAIL basic_data: got %0d/%0d ovf %b%b want 9996 ovf 00",
               $signed(d0), $signed(d1), o0, o1);
    else n_pass++;
    n_tot++;
    if (lat !== 2) $display("FAIL basic_latency: got %0d want 2 cycles after last op", lat);
    else n_pass++;
    n_tot++;
    if (opc !== 3) $display("FAIL basic_op_ready: got %0d cycles want 3", opc);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    run_job(0, -33'sd7, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (tmo || $signed(d0) !== -33'sd7 || $signed(d1) !== -33'sd7)
      $display("FAIL zero_data: got %0d/%0d tmo %b want -7", $signed(d0), $signed(d1), tmo);
    else n_pass++;
    n_tot++;
    if (lat !== 1 || opc !== 0)
      $display("FAIL zero_timing: got lat %0d op_ready %0d want lat 1 op_ready 0", lat, opc);
    else n_pass++;
  endtask

  task automatic test_overflow();
    pa[0] = -32768; pb[0] = -32768;
    run_job(1, 33'd4294967295, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (tmo || d0 !== 33'h1_3FFF_FFFF || o0 !== 1'b1)
      $display("FAIL ovf_wrap: got %0d ovf %b want -3221225473 ovf 1", $signed(d0), o0);
    else n_pass++;
    n_tot++;
    if (d1 !== 33'h0_FFFF_FFFF || o1 !== 1'b1)
      $display("FAIL ovf_sat: got %0d ovf %b want 4294967295 ovf 1", $signed(d1), o1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin pa[i] = 16'(i + 1); pb[i] = 16'(i + 1); end
    run_job(4, 33'd0, 2, 2, 5, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (tmo || d0 !== 33'd30 || d1 !== 33'd30 || o0 !== 1'b0)
      $display("FAIL bp_data: got %0d/%0d ovf %b want 30 ovf 0", $signed(d0), $signed(d1), o0);
    else n_pass++;
    n_tot++;
    if (unst) $display("FAIL bp_stable: result changed while stalled, want held");
    else n_pass++;
    n_tot++;
    if (cseen) $display("FAIL bp_cmd_ready: cmd_ready 1 while result pending, want 0");
    else n_pass++;
    n_tot++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL bp_idle: got busy %b cmd_ready %b want 0 1", busy, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_bias = 33'd123;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_a = 16'd300; op_b = 16'd301;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({cmd_ready, op_ready, res_valid, busy, res_ovf} !== 5'b10000 || res_data !== 33'd0)
      $display("FAIL midrst_outputs: got %b data %0d want 10000 data 0",
               {cmd_ready, op_ready, res_valid, busy, res_ovf}, res_data);
    else n_pass++;
    op_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    pa[0] = 7; pb[0] = -3;
    run_job(1, 33'd5, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (tmo || $signed(d0) !== -33'sd16 || $signed(d1) !== -33'sd16 || o0 !== 1'b0)
      $display("FAIL midrst_next: got %0d/%0d ovf %b want -16 ovf 0", $signed(d0), $signed(d1), o0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pa[0] = -32768; pb[0] = -32768;
    run_job(1, 33'd4294967295, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    pa[0] = 3; pb[0] = 4;
    run_job(1, 33'd1000, 0, 0, 0, d0, d1, o0, o1, lat, opc, cmdw, unst, cseen, tmo);
    n_tot++;
    if (cmdw !== 0) $display("FAIL b2b_accept: waited %0d cycles want 0", cmdw);
    else n_pass++;
    n_tot++;
    if (tmo || d0 !== 33'd1012 || d1 !== 33'd1012 || o0 !== 1'b0 || o1 !== 1'b0)
      $display("FAIL b2b_fresh: got %0d/%0d ovf %b%b want 1012 ovf 00",
               $signed(d0), $signed(d1), o0, o1);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 24; j++) begin
      int          len;
      logic [32:0] bias;
      len        = int'($urandom_range(12, 0));
      bias[31:0] = $urandom;
      bias[32]   = 1'($urandom_range(1, 0));
      for (int i = 0; i < len; i++) begin
        pa[i] = ($urandom_range(3, 0) == 0) ? -16'sd32768 : 16'($urandom);
        pb[i] = ($urandom_range(3, 0) == 0) ? -16'sd32768 : 16'($urandom);
      end
      model(len, bias, 1'b0, e0, eo0);
      model(len, bias, 1'b1, e1, eo1);
      run_job(len, bias, 0, 2, int'($urandom_range(3, 0)), d0, d1, o0, o1, lat, opc, cmdw,
              unst, cseen, tmo);
      n_tot++;
      if (tmo || d0 !== e0 || o0 !== eo0)
        $display("FAIL rand_wrap[%0d]: got %0d ovf %b want %0d ovf %b",
                 j, $signed(d0), o0, $signed(e0), eo0);
      else n_pass++;
      n_tot++;
      if (d1 !== e1 || o1 !== eo1)
        $display("FAIL rand_sat[%0d]: got %0d ovf %b want %0d ovf %b",
                 j, $signed(d1), o1, $signed(e1), eo1);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    cyc    = 0;
    op_cnt = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_backpressure();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
